// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared types and constants for the board I/O conditioning block
package board_io_pkg;

   localparam int SYNC_STAGES = 2;
   localparam int PWM_W       = 8;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      COUNT = 2'd1,
      RUN   = 2'd2
   } rst_state_t;

   // Plain-vector encodings of the reset FSM states for the state register.
   localparam logic [1:0] ST_HOLD  = HOLD;
   localparam logic [1:0] ST_COUNT = COUNT;
   localparam logic [1:0] ST_RUN   = RUN;

endpackage

// File: rtl/board_io_ctrl_debounce.sv
// rtl/board_io_ctrl_debounce.sv - one synchronised, debounced input channel with rise pulse
module debounce_ch
   import board_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
)
(
   input  logic clk_i,
   input  logic arst_i,
   input  logic din_i,
   output logic dout_o,
   output logic rise_o
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   din_s;

   assign din_s = sync_q[SYNC_STAGES-1];

   // Bring the raw pin into the clock domain.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      end
   end

   // Accept a new level only after it has differed from the stable value for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         cnt_q  <= '0;
         dout_o <= 1'b0;
         rise_o <= 1'b0;
      end else begin
         rise_o <= 1'b0;
         if (din_s == dout_o) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            dout_o <= din_s;
            cnt_q  <= '0;
            rise_o <= din_s;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - SoC reset sequencing, switch/button debounce and LED drive (PWM via BOARD_IO_LED_PWM_EN)
module board_io_ctrl
   import board_io_pkg::*;
#(
   parameter int NUM_SW          = 16,
   parameter int NUM_BTN         = 5,
   parameter int NUM_LED         = 16,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int RST_HOLD_CYCLES = 256
)
(
   input  logic               clk_i,
   input  logic               arst_i,
   input  logic               pll_locked_i,
   input  logic               rst_btn_n_i,
   input  logic [NUM_SW-1:0]  sw_i,
   input  logic [NUM_BTN-1:0] btn_i,
   input  logic [NUM_LED-1:0] led_i,
   input  logic [7:0]         led_dim_i,
   output logic               soc_arst_o,
   output logic [NUM_SW-1:0]  sw_o,
   output logic [NUM_BTN-1:0] btn_o,
   output logic [NUM_BTN-1:0] btn_rise_o,
   output logic [NUM_LED-1:0] led_o
);

   localparam int                HOLD_W   = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD_CYCLES - 1);

   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic [SYNC_STAGES-1:0] rbtn_sync_q;
   logic                   src_ok;
   logic [1:0]             state_q, state_d;
   logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic [NUM_SW-1:0]      sw_rise_unused;

   assign src_ok = lock_sync_q[SYNC_STAGES-1] & rbtn_sync_q[SYNC_STAGES-1];

   // Synchronise the reset sources; both read as "not ready" while this block is in reset.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         lock_sync_q <= '0;
         rbtn_sync_q <= '0;
      end else begin
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
         rbtn_sync_q <= {rbtn_sync_q[SYNC_STAGES-2:0], rst_btn_n_i};
      end
   end

   // Next-state logic: loss of a reset source always wins over hold-count completion.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_HOLD: begin
            hold_cnt_d = '0;
            if (src_ok) begin
               state_d = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (!src_ok) begin
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_MAX) begin
               state_d    = ST_RUN;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         ST_RUN: begin
            if (!src_ok) begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
         end
      endcase
   end

   // State register; the SoC reset is registered from the next state so it moves with the FSM.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q    <= ST_HOLD;
         hold_cnt_q <= '0;
         soc_arst_o <= 1'b1;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         soc_arst_o <= (state_d != ST_RUN);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
         debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
            .clk_i  (clk_i),
            .arst_i (arst_i),
            .din_i  (sw_i[gi]),
            .dout_o (sw_o[gi]),
            .rise_o (sw_rise_unused[gi])
         );
      end
      for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk_i  (clk_i),
            .arst_i (arst_i),
            .din_i  (btn_i[gi]),
            .dout_o (btn_o[gi]),
            .rise_o (btn_rise_o[gi])
         );
      end
   endgenerate

`ifdef BOARD_IO_LED_PWM_EN
   logic [PWM_W-1:0] pwm_cnt_q;
   logic             pwm_on;

   // Full scale is forced on so 8'hFF never shows the one-cycle dark slot of the compare.
   assign pwm_on = (led_dim_i == 8'hFF) || (pwm_cnt_q < led_dim_i);

   // Free-running 256-cycle PWM period gating the registered LED request.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         pwm_cnt_q <= '0;
         led_o     <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
         led_o     <= led_i & {NUM_LED{pwm_on}};
      end
   end
`else
   logic led_dim_unused;

   assign led_dim_unused = ^led_dim_i;

   // LEDs follow the GPIO request one cycle later.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         led_o <= '0;
      end else begin
         led_o <= led_i;
      end
   end
`endif

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Board-level I/O conditioning block sitting between the FPGA pins/clock generator and the SoC core on Nexys-class boards. It sequences the SoC reset from the PLL lock and reset button, synchronises and debounces a parametrised number of switches and buttons, and generates rising-edge pulses for interrupt buttons. It drives the LEDs from the SoC GPIO output, with optional PWM dimming.

## Interface
- NUM_SW, 16: switch channel count (1..32)
- NUM_BTN, 5: button channel count (1..8)
- NUM_LED, 16: LED channel count (1..32)
- DEBOUNCE_CYCLES, 1000000: stable-input cycles required before a debounced value changes (>=2)
- RST_HOLD_CYCLES, 256: SoC reset hold after all reset sources release (>=1)

Ports:
- clk_i  in  1  system clock (PLL output)
- arst_i  in  1  asynchronous, active-high reset of this block
- pll_locked_i  in  1  PLL lock, asynchronous to clk_i
- rst_btn_n_i  in  1  board reset button, active-low, asynchronous
- sw_i  in  NUM_SW  raw switch pins
- btn_i  in  NUM_BTN  raw button pins, active-high
- led_i  in  NUM_LED  LED request from SoC GPIO
- led_dim_i  in  8  LED duty (used only with PWM compiled in)
- soc_arst_o  out  1  SoC reset, active-high, registered
- sw_o  out  NUM_SW  debounced switches
- btn_o  out  NUM_BTN  debounced buttons
- btn_rise_o  out  NUM_BTN  one-cycle pulse on a debounced 0->1 transition
- led_o  out  NUM_LED  LED pins

## Operation
- Reset values under arst_i: soc_arst_o=1, sw_o=0, btn_o=0, btn_rise_o=0, led_o=0, FSM=HOLD, all counters 0.
- Every asynchronous input (pll_locked_i, rst_btn_n_i, sw_i, btn_i) passes through a 2-flop synchroniser reset to 0.
- Reset FSM:
  - HOLD: soc_arst_o=1, hold counter cleared. Moves to COUNT when synced lock=1 and synced rst_btn_n=1.
  - COUNT: soc_arst_o=1, counter increments. Moves to RUN when the counter reaches RST_HOLD_CYCLES-1.
  - RUN: soc_arst_o=0.
  - From COUNT or RUN, synced lock=0 or synced rst_btn_n=0 forces HOLD on the next edge. The loss condition has priority over counter completion in the same cycle.
- Debounce, per channel:
  - Counter width $clog2(DEBOUNCE_CYCLES).
  - If the synced value equals the stable value, the counter clears.
  - Otherwise the counter increments. When it equals DEBOUNCE_CYCLES-1, the stable value takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES restarts the count and never reaches the output.
- btn_rise_o[i] is high for exactly one cycle when btn_o[i] goes 0->1. There is no pulse on 1->0.
- Channels are fully independent. Simultaneous transitions on several channels are each handled on their own.
- led_o is registered from led_i; see Configuration.

## Timing
- Synchroniser latency: 2 cycles.
- A pin change held stable appears on sw_o/btn_o 2+DEBOUNCE_CYCLES cycles later.
- btn_rise_o asserts in the same cycle that btn_o rises.
- soc_arst_o deasserts 2+RST_HOLD_CYCLES+1 cycles after the later of lock and button release.
- soc_arst_o reasserts 3 cycles after a lock loss or button press: sync plus the registered FSM.
- led_o latency from led_i: 1 cycle.
- arst_i asserted mid-operation returns everything to its reset value immediately. Operation restarts from HOLD after release.

## Configuration
- Macro: BOARD_IO_LED_PWM_EN.
- Defined:
  - An 8-bit free-running PWM counter runs, reset to 0.
  - led_o[i] = led_i[i] & (pwm_cnt < led_dim_i), registered.
  - led_dim_i=8'hFF is special-cased to always on. led_dim_i=0 is always off.
  - Period is 256 cycles.
- Undefined: led_o = registered led_i, led_dim_i is ignored, and no PWM counter is synthesised.

## Structure
- Package board_io_pkg holds:
  - the FSM enum rst_state_t {HOLD, COUNT, RUN};
  - PWM_W=8;
  - the SYNC_STAGES=2 constant.
- Sub-module debounce_ch(DEBOUNCE_CYCLES): one channel, containing the synchroniser, counter, stable register and rise pulse. It is instantiated in generate loops for sw and btn; the rise output is left unused for sw.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=8.
- Reset sequencing: arst_i released with lock=1 and rst_btn_n=1 -> soc_arst_o falls exactly 11 cycles after inputs are sampled; drop lock in RUN -> soc_arst_o=1 within 3 cycles.
- Button press: btn_i[0] 0->1 held -> btn_o[0]=1 after 6 cycles and btn_rise_o[0] pulses for 1 cycle; release -> btn_o[0]=0 after 6 cycles with no pulse.
- Bounce rejection: sw_i[3] toggled at 1/2/3-cycle intervals, then held 1 -> sw_o[3] changes once, 6 cycles after the final edge.
- Simultaneous events: lock loss in the same cycle the COUNT counter reaches 7 -> FSM goes to HOLD and soc_arst_o stays 1.
- PWM (macro defined): led_i=16'hFFFF, led_dim_i=64 -> each LED is high 64 of every 256 cycles; led_dim_i=8'hFF -> constant 1; led_dim_i=0 -> constant 0.
- Mid-operation reset: assert arst_i while a debounce count is active -> all outputs at reset values next sample, soc_arst_o=1.
